// File: rtl/mmio_pkg.sv
// mmio_pkg: MMIO register map addresses and STATUS bit positions
package mmio_pkg;
  localparam logic [7:0] ADDR_LED     = 8'h00;
  localparam logic [7:0] ADDR_STATUS  = 8'h04;
  localparam logic [7:0] ADDR_IN      = 8'h08;
  localparam logic [7:0] ADDR_OUT     = 8'h0C;
  localparam logic [7:0] ADDR_SW      = 8'h10;
  localparam logic [7:0] ADDR_CYC     = 8'h14;
  localparam logic [7:0] ADDR_CYC_CLR = 8'h18;
  localparam int ST_NONEMPTY = 0;
  localparam int ST_FREE     = 1;
  localparam int ST_COUNT    = 2;
endpackage

// File: rtl/mmio_in_fifo.sv
// mmio_in_fifo: small synchronous FIFO buffering producer bytes for CPU reads
module mmio_in_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [W-1:0]               data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = mem[rd_ptr];
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= data;
endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: decodes the CPU MMIO window for LEDs, switches, byte FIFO, mailbox and cycle counter
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int IN_DEPTH = 4,
  parameter int LED_W    = 16,
  parameter int SW_W     = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [7:0]       io_addr,
  input  logic [31:0]      io_dout,
  input  logic             io_we,
  input  logic             io_rd,
  output logic [31:0]      io_din,
  input  logic [SW_W-1:0]  sw,
  output logic [LED_W-1:0] led,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_data,
  input  logic             out_ack
);
  localparam int CW = $clog2(IN_DEPTH) + 1;
  logic [7:0] fifo_head;
  logic [CW-1:0] fifo_count;
  logic fifo_full, fifo_empty;
  logic [SW_W-1:0] sw_meta, sw_sync;
  logic [31:0] cycles, status;
  logic wr_led, wr_out, wr_clr, rd_in;
  assign wr_led = io_we && io_addr == ADDR_LED;
  assign wr_out = io_we && io_addr == ADDR_OUT;
  assign wr_clr = io_we && io_addr == ADDR_CYC_CLR;
  assign rd_in = io_rd && io_addr == ADDR_IN;
  assign in_ready = !fifo_full;
  mmio_in_fifo #(.W(8), .DEPTH(IN_DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (in_valid),
    .data  (in_data),
    .pop   (rd_in),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
  always_comb begin
    status = '0;
    status[ST_NONEMPTY] = !fifo_empty;
    status[ST_FREE] = !out_valid;
    status[ST_COUNT +: 3] = 3'(fifo_count);
  end
  always_comb begin
    io_din = '0;
    case (io_addr)
      ADDR_LED:    io_din = 32'(led);
      ADDR_STATUS: io_din = status;
      ADDR_IN:     io_din = fifo_empty ? 32'd0 : 32'(fifo_head);
      ADDR_SW:     io_din = 32'(sw_sync);
      ADDR_CYC:    io_din = cycles;
      default:     io_din = '0;
    endcase
  end
  // clear loads 1 so the counter has already ticked once when read the next cycle
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      led <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      cycles <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      led <= wr_led ? io_dout[LED_W-1:0] : led;
      out_valid <= out_valid ? !out_ack : wr_out;
      out_data <= (wr_out && !out_valid) ? io_dout : out_data;
      cycles <= wr_clr ? 32'd1 : cycles + 32'd1;
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: register-map vectors plus scoreboarded FIFO, mailbox, switch, counter and reset sequences
module tb_mmio_responder;
  import mmio_pkg::*;
  logic clk = 1'b0, rstn = 1'b0;
  logic [7:0] io_addr, in_data;
  logic [31:0] io_dout, io_din, out_data;
  logic io_we, io_rd, in_valid, in_ready, out_valid, out_ack;
  logic [15:0] sw, led;
  int checks = 0, failures = 0;
  logic [7:0] fq[$];
  bit mb_valid = 1'b0;
  logic [31:0] mb_data = '0;
  typedef struct {
    bit we;
    bit rd;
    logic [7:0] addr;
    logic [31:0] dout;
    logic [31:0] din;
    logic [15:0] led;
    string name;
  } vec_t;
  vec_t vecs[11];

  mmio_responder dut (
    .clk(clk), .rstn(rstn), .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we),
    .io_rd(io_rd), .io_din(io_din), .sw(sw), .led(led), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ack(out_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    io_we = 1'b0;
    io_rd = 1'b0;
    io_addr = 8'h1C;
    io_dout = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ack = 1'b0;
  endtask

  task automatic status_chk(input string name);
    int e;
    e = (fq.size() << 2) | ((mb_valid ? 0 : 1) << 1) | (fq.size() != 0 ? 1 : 0);
    io_addr = ADDR_STATUS;
    #1;
    chk(name, io_din, 32'(e));
    idle();
  endtask

  task automatic fifo_io(input bit pv, input logic [7:0] b, input bit pr);
    logic [7:0] exp_head;
    bit acc;
    in_valid = pv;
    in_data = b;
    io_rd = pr;
    io_addr = ADDR_IN;
    #1;
    exp_head = fq.size() != 0 ? fq[0] : 8'h00;
    chk("in_ready", {31'b0, in_ready}, {31'b0, fq.size() < 4});
    chk("in_head", io_din, 32'(exp_head));
    acc = pv && fq.size() < 4;
    step();
    if (pr && fq.size() != 0) void'(fq.pop_front());
    if (acc) fq.push_back(b);
    idle();
  endtask

  task automatic mb_cyc(input bit we, input logic [31:0] d, input bit ack);
    io_we = we;
    io_addr = ADDR_OUT;
    io_dout = d;
    out_ack = ack;
    step();
    if (mb_valid) begin
      if (ack) mb_valid = 1'b0;
    end else if (we) begin
      mb_valid = 1'b1;
      mb_data = d;
    end
    idle();
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, mb_valid});
    chk("out_data", out_data, mb_data);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, ADDR_STATUS,  32'h0,        32'h2,    16'h0,    "rst_status"};
    vecs[1]  = '{1'b0, 1'b1, ADDR_IN,      32'h0,        32'h0,    16'h0,    "rst_in"};
    vecs[2]  = '{1'b1, 1'b0, ADDR_LED,     32'h0001A5A5, 32'h0,    16'hA5A5, "led_wr"};
    vecs[3]  = '{1'b0, 1'b1, ADDR_LED,     32'h0,        32'hA5A5, 16'hA5A5, "led_rd"};
    vecs[4]  = '{1'b0, 1'b1, 8'h1C,        32'h0,        32'h0,    16'hA5A5, "unmapped_1c"};
    vecs[5]  = '{1'b0, 1'b1, 8'h06,        32'h0,        32'h0,    16'hA5A5, "unmapped_06"};
    vecs[6]  = '{1'b0, 1'b1, ADDR_OUT,     32'h0,        32'h0,    16'hA5A5, "out_rd"};
    vecs[7]  = '{1'b0, 1'b1, ADDR_CYC_CLR, 32'h0,        32'h0,    16'hA5A5, "clr_rd"};
    vecs[8]  = '{1'b1, 1'b0, 8'h1C,        32'hFFFF,     32'h0,    16'hA5A5, "unmapped_wr"};
    vecs[9]  = '{1'b1, 1'b0, 8'h01,        32'h5555,     32'h0,    16'hA5A5, "unaligned_wr"};
    vecs[10] = '{1'b1, 1'b1, ADDR_LED,     32'hFFFF1234, 32'hA5A5, 16'h1234, "led_wr_rd"};
    idle();
    sw = '0;
    repeat (2) step();
    rstn = 1'b1;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    foreach (vecs[i]) begin
      io_we = vecs[i].we;
      io_rd = vecs[i].rd;
      io_addr = vecs[i].addr;
      io_dout = vecs[i].dout;
      #1;
      chk(vecs[i].name, io_din, vecs[i].din);
      step();
      chk({vecs[i].name, "_led"}, 32'(led), 32'(vecs[i].led));
      idle();
    end
    // input FIFO: fill, overflow, drain, simultaneous push/pop corners
    status_chk("fifo_empty_status");
    fifo_io(1'b1, 8'h11, 1'b0);
    fifo_io(1'b1, 8'h22, 1'b0);
    fifo_io(1'b1, 8'h33, 1'b0);
    fifo_io(1'b1, 8'h44, 1'b0);
    status_chk("fifo_full_status");
    fifo_io(1'b1, 8'h55, 1'b0);
    for (int i = 0; i < 4; i++) fifo_io(1'b0, 8'h00, 1'b1);
    status_chk("fifo_drained_status");
    fifo_io(1'b0, 8'h00, 1'b1);
    fifo_io(1'b1, 8'hAA, 1'b0);
    fifo_io(1'b1, 8'hBB, 1'b0);
    fifo_io(1'b1, 8'hCC, 1'b1);
    status_chk("fifo_pushpop_status");
    fifo_io(1'b1, 8'hDD, 1'b0);
    fifo_io(1'b1, 8'hEE, 1'b0);
    fifo_io(1'b1, 8'hFF, 1'b1);
    status_chk("fifo_fullpop_status");
    for (int i = 0; i < 3; i++) fifo_io(1'b0, 8'h00, 1'b1);
    fifo_io(1'b1, 8'h77, 1'b1);
    status_chk("fifo_emptypushpop_status");
    fifo_io(1'b0, 8'h00, 1'b1);
    status_chk("fifo_final_status");
    // mailbox: load, drop while full, ack racing a write, stray ack
    mb_cyc(1'b1, 32'hDEADBEEF, 1'b0);
    status_chk("mb_full_status");
    mb_cyc(1'b1, 32'h12345678, 1'b0);
    mb_cyc(1'b1, 32'hABCD0000, 1'b1);
    status_chk("mb_acked_status");
    mb_cyc(1'b0, 32'h0, 1'b1);
    mb_cyc(1'b1, 32'h0BADF00D, 1'b0);
    mb_cyc(1'b0, 32'h0, 1'b1);
    // switch synchroniser latency
    sw = 16'h00F0;
    io_addr = ADDR_SW;
    #1;
    chk("sw_cycle0", io_din, 32'h0);
    step();
    chk("sw_cycle1", io_din, 32'h0);
    step();
    chk("sw_cycle2", io_din, 32'h00F0);
    idle();
    // cycle counter clear then count
    io_we = 1'b1;
    io_addr = ADDR_CYC_CLR;
    step();
    io_we = 1'b0;
    io_addr = ADDR_CYC;
    #1;
    chk("cyc_after_clr", io_din, 32'd1);
    step();
    chk("cyc_next", io_din, 32'd2);
    idle();
    // asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) fifo_io(1'b1, 8'(8'h60 + i), 1'b0);
    mb_cyc(1'b1, 32'hCAFE0001, 1'b0);
    status_chk("pre_reset_status");
    #2;
    rstn = 1'b0;
    #1;
    fq.delete();
    mb_valid = 1'b0;
    mb_data = '0;
    chk("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_mid_led", 32'(led), 32'd0);
    status_chk("rst_mid_status");
    io_addr = ADDR_IN;
    #1;
    chk("rst_mid_in", io_din, 32'd0);
    idle();
    step();
    rstn = 1'b1;
    io_addr = 8'h06;
    #1;
    chk("post_rst_06", io_din, 32'd0);
    idle();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
